// File: rtl/ecc_sed_pkg.sv
// Shared constants, occupancy encoding and grouped-parity helper for the SED encoder pipe.
// Optional error injection is enabled in the top by defining ECC_SED_ERR_INJECT_EN.
package ecc_sed_pkg;

    localparam int COUNT_W = 16;
    localparam int MAX_W   = 64;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Bit g of the result is the parity of data[g*gw +: gw]; bits at or above num_groups stay 0.
    function automatic logic [MAX_W-1:0] grouped_parity(
        input logic [MAX_W-1:0] data,
        input int               gw,
        input int               num_groups,
        input logic             odd_parity
    );
        logic [MAX_W-1:0] p;
        p = '0;
        if (gw > 0) begin
            for (int i = 0; i < MAX_W; i++) begin
                if (i < gw * num_groups) begin
                    p[6'(i / gw)] = p[6'(i / gw)] ^ data[6'(i)];
                end
            end
            for (int g = 0; g < MAX_W; g++) begin
                if (g < num_groups) begin
                    p[6'(g)] = p[6'(g)] ^ odd_parity;
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/ecc_sed_parity_gen.sv
// Combinational grouped parity: one even/odd parity bit per DATA_W/NUM_GROUPS-bit slice.
module ecc_sed_parity_gen
    import ecc_sed_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NUM_GROUPS = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic [DATA_W-1:0]     data,
    output logic [NUM_GROUPS-1:0] parity
);

    localparam int   GW  = DATA_W / NUM_GROUPS;
    localparam logic ODD = (ODD_PARITY != 0);

    always_comb begin
        parity = NUM_GROUPS'(grouped_parity(MAX_W'(data), GW, NUM_GROUPS, ODD));
    end

endmodule

// File: rtl/ecc_sed_encoder_pipe.sv
// Single-error-detect encoder: grouped parity in front of a 2-entry codeword FIFO with delivery counter.
// Define ECC_SED_ERR_INJECT_EN to add inj_req/inj_mask, which corrupt a word as it is stored.
module ecc_sed_encoder_pipe
    import ecc_sed_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int NUM_GROUPS = 1,
    parameter int ODD_PARITY = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         data_valid,
    output logic                         data_ready,
    input  logic [DATA_W-1:0]            data,
`ifdef ECC_SED_ERR_INJECT_EN
    input  logic                         inj_req,
    input  logic [DATA_W+NUM_GROUPS-1:0] inj_mask,
`endif
    output logic                         enc_valid,
    input  logic                         enc_ready,
    output logic [DATA_W+NUM_GROUPS-1:0] enc_codeword,
    output logic [COUNT_W-1:0]           enc_count
);

    localparam int CW_W = DATA_W + NUM_GROUPS;

    logic [NUM_GROUPS-1:0] parity;
    logic [CW_W-1:0]       new_word;
    logic [CW_W-1:0]       slot [2];
    logic                  wr_ptr;
    logic                  rd_ptr;
    logic                  run;
    occ_t                  occ;
    occ_t                  occ_next;
    logic                  push;
    logic                  pop;

    ecc_sed_parity_gen #(
        .DATA_W     (DATA_W),
        .NUM_GROUPS (NUM_GROUPS),
        .ODD_PARITY (ODD_PARITY)
    ) u_parity_gen (
        .data   (data),
        .parity (parity)
    );

`ifdef ECC_SED_ERR_INJECT_EN
    assign new_word = {parity, data} ^ (inj_req ? inj_mask : '0);
`else
    assign new_word = {parity, data};
`endif

    // `run` holds data_ready low through reset and releases it one edge after rst rises.
    assign data_ready   = run && (occ != OCC_FULL);
    assign enc_valid    = (occ != OCC_EMPTY);
    assign enc_codeword = enc_valid ? slot[rd_ptr] : '0;
    assign push         = data_valid && data_ready;
    assign pop          = enc_valid && enc_ready;

    always_comb begin
        // NOTE: default first so every path assigns occ_next and no latch is inferred.
        occ_next = occ;
        unique case ({push, pop})
            2'b10: occ_next = (occ == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
            2'b01: occ_next = (occ == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
            default: occ_next = occ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            run       <= 1'b0;
            occ       <= OCC_EMPTY;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            enc_count <= '0;
        end else begin
            run <= 1'b1;
            occ <= occ_next;
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr    <= ~rd_ptr;
                enc_count <= enc_count + 1'b1;
            end
        end
    end

    // NOTE: payload storage is not reset; occupancy gates every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (push) begin
            slot[wr_ptr] <= new_word;
        end
    end

endmodule

// File: tb/tb_ecc_sed_encoder_pipe.sv
// Self-checking bench: three configurations (even/1 group, odd/1 group, even/2 groups) share stimulus
// and are compared every cycle against a queue-based reference model.
module tb_ecc_sed_encoder_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        data_valid;
    logic        enc_ready;
    logic [11:0] data;
    logic        inj_req;
    logic [13:0] inj_mask;

    logic        rdy0, rdy1, rdy2;
    logic        val0, val1, val2;
    logic [12:0] cw0, cw1;
    logic [13:0] cw2;
    logic [15:0] cnt0, cnt1, cnt2;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [11:0] d;
        logic [13:0] m;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_count;
    bit          m_run;

    always #5 clk = ~clk;

    ecc_sed_encoder_pipe #(.DATA_W(12), .NUM_GROUPS(1), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy0), .data(data),
`ifdef ECC_SED_ERR_INJECT_EN
        .inj_req(inj_req), .inj_mask(inj_mask[12:0]),
`endif
        .enc_valid(val0), .enc_ready(enc_ready), .enc_codeword(cw0), .enc_count(cnt0)
    );

    ecc_sed_encoder_pipe #(.DATA_W(12), .NUM_GROUPS(1), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy1), .data(data),
`ifdef ECC_SED_ERR_INJECT_EN
        .inj_req(inj_req), .inj_mask(inj_mask[12:0]),
`endif
        .enc_valid(val1), .enc_ready(enc_ready), .enc_codeword(cw1), .enc_count(cnt1)
    );

    ecc_sed_encoder_pipe #(.DATA_W(12), .NUM_GROUPS(2), .ODD_PARITY(0)) dut_g2 (
        .clk(clk), .rst(rst), .data_valid(data_valid), .data_ready(rdy2), .data(data),
`ifdef ECC_SED_ERR_INJECT_EN
        .inj_req(inj_req), .inj_mask(inj_mask),
`endif
        .enc_valid(val2), .enc_ready(enc_ready), .enc_codeword(cw2), .enc_count(cnt2)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected codeword: count ones per slice, parity = lsb of count (flipped for odd), then apply mask.
    function automatic logic [13:0] ref_cw(input logic [11:0] d, input int groups, input bit odd,
                                           input logic [13:0] m);
        logic [13:0] cw;
        logic [13:0] keep;
        int gw;
        int ones;
        gw = 12 / groups;
        cw = {2'b00, d};
        for (int g = 0; g < groups; g++) begin
            ones = 0;
            for (int b = 0; b < gw; b++) ones += int'(d[g * gw + b]);
            cw[12 + g] = ones[0] ^ odd;
        end
        keep = (groups == 2) ? 14'h3FFF : 14'h1FFF;
        return cw ^ (m & keep);
    endfunction

    task automatic model_edge();
        bit acc;
        bit dlv;
        logic [13:0] m;
`ifdef ECC_SED_ERR_INJECT_EN
        m = inj_req ? inj_mask : 14'h0;
`else
        m = 14'h0;
`endif
        if (!rst) begin
            q.delete();
            m_count = 16'h0;
            m_run   = 1'b0;
        end else begin
            acc = data_valid && m_run && (q.size() < 2);
            dlv = enc_ready && (q.size() > 0);
            if (dlv) begin
                void'(q.pop_front());
                m_count = m_count + 16'h1;
            end
            if (acc) q.push_back('{d: data, m: m});
            m_run = 1'b1;
        end
    endtask

    task automatic check_outputs();
        bit          v;
        bit          r;
        logic [13:0] e0, e1, e2;
        v  = (q.size() > 0);
        r  = m_run && (q.size() < 2);
        e0 = v ? ref_cw(q[0].d, 1, 1'b0, q[0].m) : 14'h0;
        e1 = v ? ref_cw(q[0].d, 1, 1'b1, q[0].m) : 14'h0;
        e2 = v ? ref_cw(q[0].d, 2, 1'b0, q[0].m) : 14'h0;
        check("even_valid", val0, v);
        check("even_ready", rdy0, r);
        check("even_cw", cw0, e0);
        check("even_count", cnt0, m_count);
        check("odd_valid", val1, v);
        check("odd_ready", rdy1, r);
        check("odd_cw", cw1, e1);
        check("odd_count", cnt1, m_count);
        check("g2_valid", val2, v);
        check("g2_ready", rdy2, r);
        check("g2_cw", cw2, e2);
        check("g2_count", cnt2, m_count);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        data_valid = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
    endtask

    task automatic push_one(input logic [11:0] d);
        data_valid = 1'b1;
        data       = d;
        enc_ready  = 1'b0;
        cycle();
        data_valid = 1'b0;
    endtask

    task automatic drain();
        enc_ready = 1'b1;
        cycle();
        cycle();
        enc_ready = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        data_valid = 1'b0;
        enc_ready  = 1'b0;
        data       = 12'h0;
        inj_req    = 1'b0;
        inj_mask   = 14'h0;
        m_count    = 16'h0;
        m_run      = 1'b0;

        // Reset state
        cycle();
        cycle();
        check("rst_ready", rdy0, 1'b0);
        check("rst_valid", val0, 1'b0);
        check("rst_cw", cw0, 13'h0);
        check("rst_count", cnt0, 16'h0);
        rst = 1'b1;
        cycle();
        check("ready_after_rst", rdy0, 1'b1);

        // Parity vectors, each visible one cycle after acceptance
        push_one(12'h001);
        check("even_001", cw0, 13'h1001);
        check("g2_001", cw2, 14'h1001);
        check("odd_001", cw1, 13'h0001);
        drain();
        push_one(12'h003);
        check("even_003", cw0, 13'h0003);
        drain();
        push_one(12'h000);
        check("odd_000", cw1, 13'h1000);
        check("even_000", cw0, 13'h0000);
        drain();
        push_one(12'h041);
        check("g2_041", cw2, 14'h3041);
        drain();

        // Back-pressure: A and B fill the buffer, C waits until a slot frees
        do_reset();
        enc_ready  = 1'b0;
        data_valid = 1'b1;
        data       = 12'h00A;
        cycle();
        data = 12'h00B;
        cycle();
        check("bp_ready_full", rdy0, 1'b0);
        data = 12'h00C;
        cycle();
        check("bp_hold_A", cw0, 13'h000A);
        check("bp_hold_valid", val0, 1'b1);
        enc_ready = 1'b1;
        cycle();
        check("bp_second_B", cw0, 13'h100B);
        cycle();
        data_valid = 1'b0;
        check("bp_third_C", cw0, 13'h000C);
        cycle();
        check("bp_count3", cnt0, 16'd3);
        check("bp_empty", val0, 1'b0);

        // Reset with a full buffer discards both words
        enc_ready = 1'b0;
        push_one(12'h123);
        push_one(12'h456);
        check("full_before_rst", rdy0, 1'b0);
        rst = 1'b0;
        cycle();
        check("rst_full_valid", val0, 1'b0);
        check("rst_full_count", cnt0, 16'h0);
        rst       = 1'b1;
        enc_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            check("no_stale", val0, 1'b0);
        end

`ifdef ECC_SED_ERR_INJECT_EN
        enc_ready  = 1'b0;
        inj_req    = 1'b1;
        inj_mask   = 14'h0001;
        data_valid = 1'b1;
        data       = 12'h001;
        cycle();
        inj_req = 1'b0;
        check("inj_word", cw0, 13'h1000);
        cycle();
        data_valid = 1'b0;
        enc_ready  = 1'b1;
        cycle();
        check("inj_next_clean", cw0, 13'h1001);
        cycle();
        inj_mask = 14'h0;
`endif

        // Randomised traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            rst        = ($urandom_range(0, 299) != 0);
            data_valid = ($urandom_range(0, 3) != 0);
            enc_ready  = ($urandom_range(0, 2) != 0);
            data       = 12'($urandom);
`ifdef ECC_SED_ERR_INJECT_EN
            inj_req  = ($urandom_range(0, 7) == 0);
            inj_mask = 14'($urandom);
`endif
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_sed_encoder_pipe.md
ECC_SED_ENCODER_PIPE -- requirements
Module: ecc_sed_encoder_pipe

Interface
REQ-001 Parameter DATA_W, default 12: data word width in bits; legal range 1..64.
REQ-002 Parameter NUM_GROUPS, default 1: number of parity groups (parity bits); DATA_W SHALL be divisible by NUM_GROUPS.
REQ-003 Parameter ODD_PARITY, default 0: 0 selects even parity, 1 selects odd parity.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-low.
REQ-006 data_valid  input  1  upstream word present.
REQ-007 data_ready  output  1  block can accept a word this cycle.
REQ-008 data  input  DATA_W  word to encode.
REQ-009 enc_valid  output  1  codeword present on enc_codeword.
REQ-010 enc_ready  input  1  downstream accepts the codeword this cycle.
REQ-011 enc_codeword  output  DATA_W+NUM_GROUPS  {parity[NUM_GROUPS-1:0], data}.
REQ-012 enc_count  output  16  number of codewords delivered downstream.

Function
REQ-013 GW = DATA_W/NUM_GROUPS; parity[g] SHALL be the XOR of data[g*GW +: GW], inverted when ODD_PARITY=1.
REQ-014 Input handshake: a word is accepted when data_valid && data_ready; output handshake: delivered when enc_valid && enc_ready.
REQ-015 Encoded words SHALL be held in a 2-entry FIFO with output order equal to acceptance order.
REQ-016 data_ready SHALL be 1 when occupancy < 2 and 0 at occupancy 2; it SHALL depend only on registered state.
REQ-017 Latency: a word accepted at edge N into an empty buffer SHALL appear with enc_valid=1 after edge N; throughput one word per cycle with enc_ready held high.
REQ-018 Occupancy 1 with simultaneous accept and deliver SHALL keep occupancy 1 and present the newer word next.
REQ-019 enc_codeword and enc_valid SHALL hold stable while enc_valid && !enc_ready.
REQ-020 enc_codeword SHALL be 0 whenever enc_valid=0.
REQ-021 enc_count SHALL increment by 1 per output handshake and wrap 16'hFFFF -> 16'h0000.
REQ-022 Upstream data_valid while data_ready=0 SHALL be ignored (no state change).

Reset
REQ-023 While rst=0 at a rising edge: buffer emptied, enc_valid=0, enc_codeword=0, enc_count=0, data_ready=0.
REQ-024 data_ready SHALL rise on the first edge after rst returns to 1; in-flight words at reset are discarded.

Configuration
REQ-025 Macro ECC_SED_ERR_INJECT_EN: when defined, inputs inj_req (1 bit) and inj_mask (DATA_W+NUM_GROUPS bits) SHALL exist; a word accepted with inj_req=1 SHALL be stored as codeword XOR inj_mask.
REQ-026 Without ECC_SED_ERR_INJECT_EN, the injection ports and logic SHALL be absent and codewords always clean.

Structure
REQ-027 Shared package ecc_sed_pkg SHALL hold the enc_count width constant (16) and a function computing grouped parity from data, GW, NUM_GROUPS, ODD_PARITY.
REQ-028 One sub-module ecc_sed_parity_gen (combinational grouped parity) SHALL be instantiated in front of the FIFO; FIFO and counter live in the top module.

Verification
REQ-029 DATA_W=12, NUM_GROUPS=1, even: data=12'h001 -> enc_codeword=13'h1001; data=12'h003 -> 13'h0003, each one cycle after acceptance.
REQ-030 ODD_PARITY=1: data=12'h000 -> enc_codeword=13'h1000.
REQ-031 NUM_GROUPS=2: data=12'h041 -> enc_codeword=14'h3041; data=12'h001 -> 14'h1001.
REQ-032 enc_ready=0, push 12'hA, 12'hB, 12'hC back-to-back -> first two accepted, data_ready=0 after second; raise enc_ready -> 12'hA then 12'hB delivered, then 12'hC accepted; enc_count=3 after all delivered.
REQ-033 Buffer holding 2 words, assert rst=0 for one cycle -> enc_valid=0, enc_count=0 next edge; no stale word delivered afterwards.
REQ-034 With ECC_SED_ERR_INJECT_EN, inj_req=1, inj_mask=13'h0001, data=12'h001 -> enc_codeword=13'h1000; next word with inj_req=0 encodes clean.
